unidade_controle_timeout: RTL and testbench
===========================================

Name: unidade_controle_timeout

Overview:
- Moore FSM that sequences the memory-game datapath.
- Drives address counter (E), sequence counter (S) and play register (R) control pulses.
- Adds progressive sequence playback checking and a per-play inactivity timeout.
- Sits between the top-level game circuit and `fluxo_dados`, replacing the plain control unit.

Parameters:
- TIMEOUT_CYCLES, default 5000, number of clock cycles allowed in espera_jogada before timeout (minimum 2).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; forces state inicial
- iniciar  in  1  start/restart request, level-sampled
- fimS  in  1  sequence counter at last sequence
- enderecoIgualSequencia  in  1  address counter equals current sequence length
- tem_jogada  in  1  play detected (single-cycle pulse from datapath)
- jogadaIgualMemoria  in  1  registered play equals memory content
- zeraE, contaE  out  1  address counter clear / increment
- zeraS, contaS  out  1  sequence counter clear / increment
- zeraR, registraR  out  1  play register clear / load
- pronto  out  1  game finished
- acertou  out  1  win
- errou  out  1  wrong play
- timeout  out  1  lost by inactivity
- db_estado  out  4  current state code

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset at any edge: next state inicial; all control and status outputs 0; timer cleared.
- Reset mid-game drops the round silently.
- All outputs are Moore, decoded from the state register. Each control pulse lasts exactly the one cycle spent in its state.
- States and db_estado codes, with transitions:
  - inicial 0000: iniciar=1 -> preparacao, else stay.
  - preparacao 0001: zeraE=zeraS=zeraR=1 -> inicia_sequencia.
  - inicia_sequencia 0010: zeraE=1 -> espera_jogada.
  - espera_jogada 0011:
    - tem_jogada=1 -> registra.
    - else if timer expired -> fim_timeout.
    - else stay.
    - tem_jogada wins over a simultaneous expiry.
  - registra 0100: registraR=1 -> comparacao.
  - comparacao 0101:
    - jogadaIgualMemoria=0 -> fim_errou.
    - else enderecoIgualSequencia=1 -> ultima_sequencia.
    - else -> proximo_endereco.
  - proximo_endereco 0110: contaE=1 -> espera_jogada.
  - ultima_sequencia 0111: fimS=1 -> fim_acertou, else -> proxima_sequencia.
  - proxima_sequencia 1000: contaS=1 -> inicia_sequencia.
  - fim_acertou 1010: pronto=acertou=1.
  - fim_errou 1110: pronto=errou=1.
  - fim_timeout 1101: pronto=timeout=1.
  - All three fim_* states: iniciar=1 -> preparacao, else stay.
  - Unused codes -> inicial.
- Timer:
  - Width $clog2(TIMEOUT_CYCLES).
  - Counts up by 1 each cycle in espera_jogada; held at 0 in every other state.
  - It therefore restarts on every entry to espera_jogada.
  - Expired when count == TIMEOUT_CYCLES-1.
  - Timeout is taken on the edge ending the TIMEOUT_CYCLES-th consecutive cycle in espera_jogada.
- Latency:
  - iniciar high at edge k -> preparacao at k.
  - First espera_jogada at k+2.
  - tem_jogada at edge m -> comparison result state at m+2.
- iniciar held high in a fim_* state restarts the game immediately. iniciar is ignored in all other non-inicial states.

Optional Feature:
- Macro UNIDADE_CONTROLE_TIMEOUT_EN.
- Defined: timer and fim_timeout exist as above.
- Undefined:
  - No timer logic; espera_jogada waits indefinitely.
  - fim_timeout is unreachable and its code decodes -> inicial.
  - timeout is tied 0.
  - TIMEOUT_CYCLES is ignored.

Decomposition:
- Shared package `jogo_pkg`: 4-bit state code localparams (names above), db_estado width constant.
- One sub-module `contador_timeout`:
  - inputs clock, reset, enable (state==espera_jogada); output expirou.
  - Parameter TIMEOUT_CYCLES; synchronous clear when enable=0.
  - Instantiated only under UNIDADE_CONTROLE_TIMEOUT_EN.

Test Plan:
- Bench uses TIMEOUT_CYCLES=8.
- Reset held 2 cycles, then iniciar=1 one cycle -> db_estado 0000, 0001, 0010, 0011 on successive edges. zeraE/zeraS/zeraR high exactly in 0001. zeraE high in 0010.
- Full win:
  - fimS=1 at sequence 0.
  - Pulse tem_jogada with jogadaIgualMemoria=1 and enderecoIgualSequencia=1.
  - Expect 0100, 0101, 0111, 1010.
  - Expect pronto=acertou=1, errou=timeout=0.
- Two-step round:
  - fimS=0, enderecoIgualSequencia=0 on first play, then 1 on second.
  - Expect contaE pulse (0110), then 0111, then contaS pulse (1000), then 0010 -> 0011.
- Wrong play: jogadaIgualMemoria=0 at comparacao -> 1110, pronto=errou=1. iniciar=1 -> 0001 next edge.
- Timeout:
  - Idle in 0011 for 8 cycles -> 1101, timeout=1.
  - Repeat with tem_jogada on the 8th cycle -> 0100, no timeout.
  - Without macro: 50 idle cycles stay 0011, timeout=0.
- Reset asserted while in 0110 -> 0000 next edge, all outputs 0. Unused code forced via force/release -> 0000.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game control unit: state codes, state type and
// the Moore output decode used by the FSM.
package jogo_pkg;

    localparam int ESTADO_W = 4;

    localparam logic [ESTADO_W-1:0] ST_INICIAL           = 4'b0000;
    localparam logic [ESTADO_W-1:0] ST_PREPARACAO        = 4'b0001;
    localparam logic [ESTADO_W-1:0] ST_INICIA_SEQUENCIA  = 4'b0010;
    localparam logic [ESTADO_W-1:0] ST_ESPERA_JOGADA     = 4'b0011;
    localparam logic [ESTADO_W-1:0] ST_REGISTRA          = 4'b0100;
    localparam logic [ESTADO_W-1:0] ST_COMPARACAO        = 4'b0101;
    localparam logic [ESTADO_W-1:0] ST_PROXIMO_ENDERECO  = 4'b0110;
    localparam logic [ESTADO_W-1:0] ST_ULTIMA_SEQUENCIA  = 4'b0111;
    localparam logic [ESTADO_W-1:0] ST_PROXIMA_SEQUENCIA = 4'b1000;
    localparam logic [ESTADO_W-1:0] ST_FIM_ACERTOU       = 4'b1010;
    localparam logic [ESTADO_W-1:0] ST_FIM_ERROU         = 4'b1110;
    localparam logic [ESTADO_W-1:0] ST_FIM_TIMEOUT       = 4'b1101;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL           = ST_INICIAL,
        PREPARACAO        = ST_PREPARACAO,
        INICIA_SEQUENCIA  = ST_INICIA_SEQUENCIA,
        ESPERA_JOGADA     = ST_ESPERA_JOGADA,
        REGISTRA          = ST_REGISTRA,
        COMPARACAO        = ST_COMPARACAO,
        PROXIMO_ENDERECO  = ST_PROXIMO_ENDERECO,
        ULTIMA_SEQUENCIA  = ST_ULTIMA_SEQUENCIA,
        PROXIMA_SEQUENCIA = ST_PROXIMA_SEQUENCIA,
        FIM_ACERTOU       = ST_FIM_ACERTOU,
        FIM_ERROU         = ST_FIM_ERROU,
        FIM_TIMEOUT       = ST_FIM_TIMEOUT
    } estado_t;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_s;
        logic conta_s;
        logic zera_r;
        logic registra_r;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } saidas_t;

    // Moore decode: each control pulse belongs to exactly one state.
    function automatic saidas_t decodifica_saidas(input estado_t estado);
        saidas_t s;
        s = '0;
        case (estado)
            PREPARACAO: begin
                s.zera_e = 1'b1;
                s.zera_s = 1'b1;
                s.zera_r = 1'b1;
            end
            INICIA_SEQUENCIA:  s.zera_e     = 1'b1;
            REGISTRA:          s.registra_r = 1'b1;
            PROXIMO_ENDERECO:  s.conta_e    = 1'b1;
            PROXIMA_SEQUENCIA: s.conta_s    = 1'b1;
            FIM_ACERTOU: begin
                s.pronto  = 1'b1;
                s.acertou = 1'b1;
            end
            FIM_ERROU: begin
                s.pronto = 1'b1;
                s.errou  = 1'b1;
            end
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            FIM_TIMEOUT: begin
                s.pronto  = 1'b1;
                s.timeout = 1'b1;
            end
`endif
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Inactivity timer for the play-wait state: counts while enabled, cleared otherwise,
// flags expiry on the TIMEOUT_CYCLES-th consecutive enabled cycle.
module contador_timeout
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic expirou
);

    localparam int CONT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CONT_W-1:0] LIMITE     = CONT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CONT_W-1:0] PRE_LIMITE = CONT_W'(TIMEOUT_CYCLES - 2);

    logic [CONT_W-1:0] contagem_r;
    logic              expirou_r;

    // Counter: restarts from zero on every entry because it is held clear while disabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem_r <= '0;
        end else if (!enable) begin
            contagem_r <= '0;
        end else begin
            contagem_r <= contagem_r + CONT_W'(1);
        end
    end

    // Expiry flag registered one cycle early so it is high exactly while count == LIMITE.
    always_ff @(posedge clock) begin
        if (reset) begin
            expirou_r <= 1'b0;
        end else if (!enable) begin
            expirou_r <= 1'b0;
        end else begin
            expirou_r <= (contagem_r == PRE_LIMITE) && (contagem_r != LIMITE);
        end
    end

    assign expirou = expirou_r;

endmodule

// File: rtl/unidade_controle_timeout.sv
// Memory-game control unit with progressive sequence checking and, when
// UNIDADE_CONTROLE_TIMEOUT_EN is defined, a per-play inactivity timeout.
module unidade_controle_timeout
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                fimS,
    input  logic                enderecoIgualSequencia,
    input  logic                tem_jogada,
    input  logic                jogadaIgualMemoria,
    output logic                zeraE,
    output logic                contaE,
    output logic                zeraS,
    output logic                contaS,
    output logic                zeraR,
    output logic                registraR,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t estado_r;
    estado_t estado_prox_s;
    saidas_t saidas_r;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    logic expirou_s;

    contador_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_contador_timeout (
        .clock  (clock),
        .reset  (reset),
        .enable (estado_r == ESPERA_JOGADA),
        .expirou(expirou_s)
    );
`endif

    // Next-state logic; a play arriving on the expiry cycle still wins.
    always_comb begin
        estado_prox_s = INICIAL;
        case (estado_r)
            INICIAL: begin
                if (iniciar) begin
                    estado_prox_s = PREPARACAO;
                end else begin
                    estado_prox_s = INICIAL;
                end
            end
            PREPARACAO:       estado_prox_s = INICIA_SEQUENCIA;
            INICIA_SEQUENCIA: estado_prox_s = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (tem_jogada) begin
                    estado_prox_s = REGISTRA;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
                end else if (expirou_s) begin
                    estado_prox_s = FIM_TIMEOUT;
`endif
                end else begin
                    estado_prox_s = ESPERA_JOGADA;
                end
            end
            REGISTRA: estado_prox_s = COMPARACAO;
            COMPARACAO: begin
                if (!jogadaIgualMemoria) begin
                    estado_prox_s = FIM_ERROU;
                end else if (enderecoIgualSequencia) begin
                    estado_prox_s = ULTIMA_SEQUENCIA;
                end else begin
                    estado_prox_s = PROXIMO_ENDERECO;
                end
            end
            PROXIMO_ENDERECO: estado_prox_s = ESPERA_JOGADA;
            ULTIMA_SEQUENCIA: begin
                if (fimS) begin
                    estado_prox_s = FIM_ACERTOU;
                end else begin
                    estado_prox_s = PROXIMA_SEQUENCIA;
                end
            end
            PROXIMA_SEQUENCIA: estado_prox_s = INICIA_SEQUENCIA;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
`else
            FIM_ACERTOU, FIM_ERROU: begin
`endif
                if (iniciar) begin
                    estado_prox_s = PREPARACAO;
                end else begin
                    estado_prox_s = estado_r;
                end
            end
            default: estado_prox_s = INICIAL;
        endcase
    end

    // State and outputs registered together; outputs always match the decode of estado_r.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r <= INICIAL;
            saidas_r <= '0;
        end else begin
            estado_r <= estado_prox_s;
            saidas_r <= decodifica_saidas(estado_prox_s);
        end
    end

    assign zeraE     = saidas_r.zera_e;
    assign contaE    = saidas_r.conta_e;
    assign zeraS     = saidas_r.zera_s;
    assign contaS    = saidas_r.conta_s;
    assign zeraR     = saidas_r.zera_r;
    assign registraR = saidas_r.registra_r;
    assign pronto    = saidas_r.pronto;
    assign acertou   = saidas_r.acertou;
    assign errou     = saidas_r.errou;
    assign timeout   = saidas_r.timeout;
    assign db_estado = estado_r;

endmodule

// File: tb/tb_unidade_controle_timeout.sv
// Directed self-checking bench for unidade_controle_timeout (TIMEOUT_CYCLES = 8).
module tb_unidade_controle_timeout;
    import jogo_pkg::*;

    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_PREP = 10'b1010100000;
    localparam logic [9:0] O_INI  = 10'b1000000000;
    localparam logic [9:0] O_REG  = 10'b0000010000;
    localparam logic [9:0] O_CE   = 10'b0100000000;
    localparam logic [9:0] O_CS   = 10'b0001000000;
    localparam logic [9:0] O_WIN  = 10'b0000001100;
    localparam logic [9:0] O_ERR  = 10'b0000001010;
    localparam logic [9:0] O_TO   = 10'b0000001001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       fimS = 1'b0;
    logic       eis = 1'b0;
    logic       tem_jogada = 1'b0;
    logic       jim = 1'b0;
    logic       zeraE, contaE, zeraS, contaS, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [9:0] outs;
    int         checks = 0;
    int         errors = 0;

    unidade_controle_timeout #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clk), .reset(reset), .iniciar(iniciar), .fimS(fimS),
        .enderecoIgualSequencia(eis), .tem_jogada(tem_jogada),
        .jogadaIgualMemoria(jim), .zeraE(zeraE), .contaE(contaE),
        .zeraS(zeraS), .contaS(contaS), .zeraR(zeraR), .registraR(registraR),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    assign outs = {zeraE, contaE, zeraS, contaS, zeraR, registraR, pronto, acertou, errou, timeout};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // bits: iniciar, fimS, enderecoIgualSequencia, tem_jogada, jogadaIgualMemoria
    task automatic drive(input logic [4:0] v);
        {iniciar, fimS, eis, tem_jogada, jim} = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(5'b00000);
        for (int i = 0; i < 2; i++) begin
            step();
            if ({db_estado, outs} !== {4'b0000, O_NONE}) begin
                errors++;
                $display("FAIL reset[%0d]: got st=%b out=%b, expected st=0000 out=%b", i, db_estado, outs, O_NONE);
            end
            checks++;
        end
        reset = 1'b0;
    endtask

    task automatic test_start();
        logic [4:0]  vin [3];
        logic [13:0] vexp[3];
        vin  = '{5'b10000, 5'b00000, 5'b00000};
        vexp = '{{4'b0001, O_PREP}, {4'b0010, O_INI}, {4'b0011, O_NONE}};
        for (int i = 0; i < 3; i++) begin
            drive(vin[i]);
            step();
            if ({db_estado, outs} !== vexp[i]) begin
                errors++;
                $display("FAIL start[%0d]: got %b_%b, expected %b_%b", i, db_estado, outs, vexp[i][13:10], vexp[i][9:0]);
            end
            checks++;
        end
    endtask

    task automatic test_win();
        logic [4:0]  vin [5];
        logic [13:0] vexp[5];
        vin  = '{5'b01011, 5'b01101, 5'b01101, 5'b01101, 5'b00000};
        vexp = '{{4'b0100, O_REG}, {4'b0101, O_NONE}, {4'b0111, O_NONE},
                 {4'b1010, O_WIN}, {4'b1010, O_WIN}};
        for (int i = 0; i < 5; i++) begin
            drive(vin[i]);
            step();
            if ({db_estado, outs} !== vexp[i]) begin
                errors++;
                $display("FAIL win[%0d]: got %b_%b, expected %b_%b", i, db_estado, outs, vexp[i][13:10], vexp[i][9:0]);
            end
            checks++;
        end
    endtask

    task automatic test_two_step();
        logic [4:0]  vin [13];
        logic [13:0] vexp[13];
        vin  = '{5'b10000, 5'b00000, 5'b00000, 5'b00011, 5'b00001, 5'b00001, 5'b00001,
                 5'b00111, 5'b10101, 5'b10101, 5'b00101, 5'b00000, 5'b00000};
        vexp = '{{4'b0001, O_PREP}, {4'b0010, O_INI}, {4'b0011, O_NONE}, {4'b0100, O_REG},
                 {4'b0101, O_NONE}, {4'b0110, O_CE}, {4'b0011, O_NONE}, {4'b0100, O_REG},
                 {4'b0101, O_NONE}, {4'b0111, O_NONE}, {4'b1000, O_CS}, {4'b0010, O_INI},
                 {4'b0011, O_NONE}};
        for (int i = 0; i < 13; i++) begin
            drive(vin[i]);
            step();
            if ({db_estado, outs} !== vexp[i]) begin
                errors++;
                $display("FAIL two_step[%0d]: got %b_%b, expected %b_%b", i, db_estado, outs, vexp[i][13:10], vexp[i][9:0]);
            end
            checks++;
        end
    endtask

    task automatic test_wrong();
        logic [4:0]  vin [7];
        logic [13:0] vexp[7];
        vin  = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00000};
        vexp = '{{4'b0100, O_REG}, {4'b0101, O_NONE}, {4'b1110, O_ERR}, {4'b1110, O_ERR},
                 {4'b0001, O_PREP}, {4'b0010, O_INI}, {4'b0011, O_NONE}};
        for (int i = 0; i < 7; i++) begin
            drive(vin[i]);
            step();
            if ({db_estado, outs} !== vexp[i]) begin
                errors++;
                $display("FAIL wrong[%0d]: got %b_%b, expected %b_%b", i, db_estado, outs, vexp[i][13:10], vexp[i][9:0]);
            end
            checks++;
        end
    endtask

    task automatic test_timeout();
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        // Entered espera_jogada on the previous edge: 7 more edges stay, the 8th times out.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 7; i++) begin
                drive(5'b00000);
                step();
                if ({db_estado, outs} !== {4'b0011, O_NONE}) begin
                    errors++;
                    $display("FAIL timeout_wait[%0d.%0d]: got %b_%b, expected 0011_%b", r, i, db_estado, outs, O_NONE);
                end
                checks++;
            end
            if (r == 1) begin
                // play on the expiry cycle wins, then re-enter espera_jogada with a fresh timer
                drive(5'b00011);
                step();
                if ({db_estado, outs} !== {4'b0100, O_REG}) begin
                    errors++;
                    $display("FAIL timeout_play_wins: got %b_%b, expected 0100_%b", db_estado, outs, O_REG);
                end
                checks++;
                drive(5'b00001); step();
                drive(5'b00001); step();
                drive(5'b00000); step();
                if ({db_estado, outs} !== {4'b0011, O_NONE}) begin
                    errors++;
                    $display("FAIL timeout_reenter: got %b_%b, expected 0011_%b", db_estado, outs, O_NONE);
                end
                checks++;
            end else begin
                drive(5'b00000);
                step();
                if ({db_estado, outs} !== {4'b1101, O_TO}) begin
                    errors++;
                    $display("FAIL timeout_fire[%0d]: got %b_%b, expected 1101_%b", r, db_estado, outs, O_TO);
                end
                checks++;
                if (r == 0) begin
                    drive(5'b10000); step();
                    drive(5'b00000); step();
                    step();
                end
            end
        end
        drive(5'b00000);
        step();
        if ({db_estado, outs} !== {4'b1101, O_TO}) begin
            errors++;
            $display("FAIL timeout_hold: got %b_%b, expected 1101_%b", db_estado, outs, O_TO);
        end
        checks++;
`else
        for (int i = 0; i < 50; i++) begin
            drive(5'b00000);
            step();
            if ({db_estado, outs} !== {4'b0011, O_NONE}) begin
                errors++;
                $display("FAIL no_timeout[%0d]: got %b_%b, expected 0011_%b", i, db_estado, outs, O_NONE);
            end
            checks++;
        end
`endif
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        drive(5'b00000);
        step();
        reset = 1'b0;
        drive(5'b10000); step();
        drive(5'b00000); step();
        step();
        drive(5'b00011); step();
        drive(5'b00001); step();
        step();
        if ({db_estado, outs} !== {4'b0110, O_CE}) begin
            errors++;
            $display("FAIL reset_mid_setup: got %b_%b, expected 0110_%b", db_estado, outs, O_CE);
        end
        checks++;
        reset = 1'b1;
        drive(5'b11111);
        step();
        if ({db_estado, outs} !== {4'b0000, O_NONE}) begin
            errors++;
            $display("FAIL reset_mid: got %b_%b, expected 0000_%b", db_estado, outs, O_NONE);
        end
        checks++;
        reset = 1'b0;
        drive(5'b00000);
        step();
        if ({db_estado, outs} !== {4'b0000, O_NONE}) begin
            errors++;
            $display("FAIL reset_mid_after: got %b_%b, expected 0000_%b", db_estado, outs, O_NONE);
        end
        checks++;
    endtask

    task automatic test_unused_code();
        logic [3:0] codes[2];
        int         ncodes;
        codes  = '{4'b1111, 4'b1101};
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        ncodes = 1;
`else
        ncodes = 2;
`endif
        for (int c = 0; c < ncodes; c++) begin
            // park in fim_errou, which would hold without iniciar
            drive(5'b10000); step();
            drive(5'b00000); step();
            step();
            drive(5'b00010); step();
            drive(5'b00000); step();
            step();
            if ({db_estado, outs} !== {4'b1110, O_ERR}) begin
                errors++;
                $display("FAIL unused_setup[%0d]: got %b_%b, expected 1110_%b", c, db_estado, outs, O_ERR);
            end
            checks++;
            @(negedge clk);
            force dut.estado_r = estado_t'(codes[c]);
            #1;
            release dut.estado_r;
            step();
            if ({db_estado, outs} !== {4'b0000, O_NONE}) begin
                errors++;
                $display("FAIL unused_code[%b]: got %b_%b, expected 0000_%b", codes[c], db_estado, outs, O_NONE);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_win();
        test_two_step();
        test_wrong();
        test_timeout();
        test_reset_mid();
        test_unused_code();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
